// File: rtl/uart_pkg.sv
// Shared parity-mode constants and receiver FSM state type.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: free-running divide-by-CLK_DIV, restartable on a start edge.
module uart_baud_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parameterized UART receiver: oversampled centre sampling, optional parity, 1-2 stop bits.
// state     | meaning
// ST_IDLE   | waiting for a synchronized falling edge with en_rx high
// ST_START  | confirming the start bit at its centre (false-start filter)
// ST_DATA   | shifting payload bits, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking stop bits; last one publishes the frame
// ST_BREAK  | final stop bit was low; hold until the line returns high
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int CLK_DIV    = 4,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_rx,
  input  logic                 u_rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 u_rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $fatal(1, "uart_rx_param: DATA_BITS must be 5..9");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $fatal(1, "uart_rx_param: CLK_DIV must be >= 2");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $fatal(1, "uart_rx_param: OVERSAMPLE must be even and >= 8");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
    $fatal(1, "uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $fatal(1, "uart_rx_param: STOP_BITS must be 1 or 2");
  end

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  rx_state_e            state, state_nxt;
  logic                 rx_s1, rx_s2, rx_d;
  logic [OS_W-1:0]      os_cnt, os_cnt_nxt;
  logic [3:0]           bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt, data_nxt;
  logic                 par_bit, par_nxt;
  logic                 stop_err, serr_nxt;
  logic                 perr_nxt, ferr_nxt, done_nxt;
  logic                 restart, tick, sample, start_edge, exp_par;

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  assign start_edge = rx_d & ~rx_s2;
  assign sample     = tick & ((state == ST_START) ? (os_cnt == OS_MID) : (os_cnt == OS_LAST));
  assign exp_par    = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_d       <= 1'b1;
      state      <= ST_IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      stop_err   <= 1'b0;
      data       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      u_rx_done  <= 1'b0;
    end else begin
      rx_s1      <= u_rx;
      rx_s2      <= rx_s1;
      rx_d       <= rx_s2;
      state      <= state_nxt;
      os_cnt     <= os_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      par_bit    <= par_nxt;
      stop_err   <= serr_nxt;
      data       <= data_nxt;
      parity_err <= perr_nxt;
      frame_err  <= ferr_nxt;
      u_rx_done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    os_cnt_nxt  = os_cnt;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_nxt     = par_bit;
    serr_nxt    = stop_err;
    data_nxt    = data;
    perr_nxt    = parity_err;
    ferr_nxt    = frame_err;
    done_nxt    = 1'b0;
    restart     = 1'b0;

    if (tick && state != ST_IDLE && state != ST_BREAK) begin
      os_cnt_nxt = sample ? '0 : os_cnt + 1'b1;
    end

    case (state)
      ST_IDLE: begin
        os_cnt_nxt  = '0;
        bit_cnt_nxt = '0;
        if (en_rx && start_edge) begin
          state_nxt = ST_START;
          restart   = 1'b1;
        end
      end
      ST_START: begin
        if (sample) begin
          state_nxt = rx_s2 ? ST_IDLE : ST_DATA;
          serr_nxt  = 1'b0;
        end
      end
      ST_DATA: begin
        if (sample) begin
          shreg_nxt = {rx_s2, shreg[DATA_BITS-1:1]};
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_nxt = '0;
            state_nxt   = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (sample) begin
          par_nxt   = rx_s2;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) begin
          if (bit_cnt == STOP_LAST) begin
            // Publish the frame; a low final stop bit may be a break, so wait it out.
            data_nxt  = shreg;
            perr_nxt  = (PARITY != PAR_NONE) && (par_bit != exp_par);
            ferr_nxt  = stop_err | ~rx_s2;
            done_nxt  = 1'b1;
            state_nxt = rx_s2 ? ST_IDLE : ST_BREAK;
          end else begin
            serr_nxt    = stop_err | ~rx_s2;
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s2) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench: vector table, hand-built corner sequences and random frames vs. a line-level model.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int BIT = 64;          // clk per bit: CLK_DIV * OVERSAMPLE
  localparam int LAT = BIT / 2 + 3; // last stop-bit centre, then 2 sync flops + 1 register

  logic       clk, rst;
  logic [1:0] en, rx, done, perr, ferr, busy;
  logic [7:0] data0, data1;
  int         cyc = 0;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } ev_t;
  ev_t evq0[$];
  ev_t evq1[$];

  typedef struct {
    int         sel;
    logic [7:0] pay;
    int         pbit;
    logic       slow;
    int         en_mode;
    logic       exp_pulse;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;
  vec_t tbl[9];

  uart_rx_param dut0 (
    .clk (clk), .rst (rst), .en_rx (en[0]), .u_rx (rx[0]), .data (data0),
    .u_rx_done (done[0]), .parity_err (perr[0]), .frame_err (ferr[0]), .busy (busy[0])
  );

  uart_rx_param #(.PARITY(PAR_EVEN)) dut1 (
    .clk (clk), .rst (rst), .en_rx (en[1]), .u_rx (rx[1]), .data (data1),
    .u_rx_done (done[1]), .parity_err (perr[1]), .frame_err (ferr[1]), .busy (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    ev_t e;
    if (done[0]) begin
      e.cyc = cyc; e.d = data0; e.pe = perr[0]; e.fe = ferr[0];
      evq0.push_back(e);
    end
    if (done[1]) begin
      e.cyc = cyc; e.d = data1; e.pe = perr[1]; e.fe = ferr[1];
      evq1.push_back(e);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; drives start, 8 data bits LSB first, optional parity bit, one stop bit.
  task automatic send_frame(input int sel, input logic [7:0] pay, input int pbit, input logic stop_low,
                            input logic idle_val, input int drop_en_at, output int t0);
    logic q[$];
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(pay[i]);
    if (pbit >= 0) q.push_back(pbit[0]);
    q.push_back(~stop_low);
    t0 = cyc;
    foreach (q[i]) begin
      rx[sel] = q[i];
      if (i == drop_en_at) en[sel] = 1'b0;
      repeat (BIT) @(negedge clk);
    end
    rx[sel] = idle_val;
  endtask

  task automatic expect_ev(input int sel, input string nm, input int exp_cyc,
                           input logic [7:0] d, input logic pe, input logic fe);
    ev_t e;
    int  n;
    n = (sel == 1) ? evq1.size() : evq0.size();
    chk({nm, ".pulses"}, n, 1);
    if (n > 0) begin
      e = (sel == 1) ? evq1.pop_front() : evq0.pop_front();
      chk({nm, ".data"}, e.d, d);
      chk({nm, ".parity_err"}, e.pe, pe);
      chk({nm, ".frame_err"}, e.fe, fe);
      chk({nm, ".done_cycle"}, e.cyc, exp_cyc);
    end
    evq0.delete();
    evq1.delete();
  endtask

  int         t0, t1, bc, nb, pb;
  logic [7:0] pay, live_d;
  logic       slow, live_pe, live_fe, epe;
  ev_t        ea, eb;

  initial begin
    tbl[0] = '{0, 8'hA5, -1, 1'b0, 0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{1, 8'h3C,  1, 1'b0, 0, 1'b1, 8'h3C, 1'b1, 1'b0};
    tbl[2] = '{1, 8'h3C,  0, 1'b0, 0, 1'b1, 8'h3C, 1'b0, 1'b0};
    tbl[3] = '{1, 8'h07,  0, 1'b0, 0, 1'b1, 8'h07, 1'b1, 1'b0};
    tbl[4] = '{1, 8'h07,  1, 1'b0, 0, 1'b1, 8'h07, 1'b0, 1'b0};
    tbl[5] = '{0, 8'h3B, -1, 1'b0, 1, 1'b1, 8'h3B, 1'b0, 1'b0};
    tbl[6] = '{0, 8'hC3, -1, 1'b0, 2, 1'b0, 8'h3B, 1'b0, 1'b0};
    tbl[7] = '{0, 8'h5A, -1, 1'b1, 0, 1'b1, 8'h5A, 1'b0, 1'b1};
    tbl[8] = '{1, 8'hE1,  0, 1'b1, 0, 1'b1, 8'hE1, 1'b0, 1'b1};

    rst = 1'b1; en = 2'b11; rx = 2'b11;
    idle(3);
    chk("reset.data0", data0, 8'h00);
    chk("reset.data1", data1, 8'h00);
    chk("reset.done_perr_ferr_busy", {done, perr, ferr, busy}, 8'h00);
    rst = 1'b0;
    idle(8);

    for (int i = 0; i < 9; i++) begin
      en[tbl[i].sel] = (tbl[i].en_mode != 2);
      send_frame(tbl[i].sel, tbl[i].pay, tbl[i].pbit, tbl[i].slow, 1'b1,
                 (tbl[i].en_mode == 1) ? 3 : -1, t0);
      idle(2 * BIT);
      en[tbl[i].sel] = 1'b1;
      nb = (tbl[i].pbit >= 0) ? 10 : 9;
      if (tbl[i].exp_pulse)
        expect_ev(tbl[i].sel, $sformatf("vec%0d", i), t0 + LAT + BIT * nb,
                  tbl[i].exp_d, tbl[i].exp_pe, tbl[i].exp_fe);
      else begin
        chk($sformatf("vec%0d.no_pulse", i), evq0.size() + evq1.size(), 0);
        evq0.delete();
        evq1.delete();
      end
      live_d  = (tbl[i].sel == 1) ? data1 : data0;
      live_pe = perr[tbl[i].sel];
      live_fe = ferr[tbl[i].sel];
      chk($sformatf("vec%0d.held_outputs", i), {live_d, live_pe, live_fe},
          {tbl[i].exp_d, tbl[i].exp_pe, tbl[i].exp_fe});
      chk($sformatf("vec%0d.busy_after", i), busy[tbl[i].sel], 1'b0);
    end

    // Break: low stop bit, line held low for 20 bit times, then a clean frame.
    send_frame(0, 8'h12, -1, 1'b1, 1'b0, -1, t0);
    idle(10 * BIT);
    chk("break.busy_held_low", busy[0], 1'b1);
    idle(10 * BIT);
    expect_ev(0, "break", t0 + LAT + BIT * 9, 8'h12, 1'b0, 1'b1);
    rx[0] = 1'b1;
    idle(2 * BIT);
    chk("break.busy_released", busy[0], 1'b0);
    send_frame(0, 8'h55, -1, 1'b0, 1'b1, -1, t0);
    idle(2 * BIT);
    expect_ev(0, "after_break", t0 + LAT + BIT * 9, 8'h55, 1'b0, 1'b0);

    // 16-clk low glitch must be rejected as a false start.
    bc = 0;
    rx[0] = 1'b0;
    for (int j = 0; j < 3 * BIT; j++) begin
      if (j == 16) rx[0] = 1'b1;
      @(negedge clk);
      if (busy[0]) bc++;
    end
    chk("glitch.no_pulse", evq0.size(), 0);
    chk("glitch.busy_1_to_40", (bc > 0 && bc <= 40), 1'b1);

    // Back-to-back frames with no idle gap.
    send_frame(0, 8'h00, -1, 1'b0, 1'b1, -1, t0);
    send_frame(0, 8'hFF, -1, 1'b0, 1'b1, -1, t1);
    idle(2 * BIT);
    chk("b2b.pulses", evq0.size(), 2);
    if (evq0.size() == 2) begin
      ea = evq0.pop_front();
      eb = evq0.pop_front();
      chk("b2b.first_data", ea.d, 8'h00);
      chk("b2b.second_data", eb.d, 8'hFF);
      chk("b2b.first_cycle", ea.cyc, t0 + LAT + BIT * 9);
      chk("b2b.spacing", eb.cyc - ea.cyc, 640);
    end
    evq0.delete();

    // Reset 200 clk into a frame.
    rx[0] = 1'b0;
    idle(BIT);
    rx[0] = 1'b1;
    idle(200 - BIT);
    chk("rst_mid.busy_before", busy[0], 1'b1);
    #1 rst = 1'b1;
    #1 chk("rst_mid.outputs_cleared", {data0, done[0], perr[0], ferr[0], busy[0]}, 12'h000);
    idle(3);
    rst = 1'b0;
    idle(4 * BIT);
    chk("rst_mid.no_pulse", evq0.size(), 0);
    send_frame(0, 8'h81, -1, 1'b0, 1'b1, -1, t0);
    idle(2 * BIT);
    expect_ev(0, "after_rst", t0 + LAT + BIT * 9, 8'h81, 1'b0, 1'b0);

    // Random frames: expected flags from line-level rules (even total ones, stop bit high).
    for (int k = 0; k < 16; k++) begin
      pay  = 8'($urandom);
      slow = ($urandom_range(4) == 0);
      pb   = (k % 2 == 1) ? int'($urandom_range(1)) : -1;
      epe  = (pb >= 0) && ((($countones(pay) + pb) % 2) == 1);
      send_frame(k % 2, pay, pb, slow, 1'b1, -1, t0);
      idle(2 * BIT);
      expect_ev(k % 2, $sformatf("rand%0d", k), t0 + LAT + BIT * ((pb >= 0) ? 10 : 9),
                pay, epe, slow);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 DATA_BITS, 8, payload width; legal range 5..9.
REQ-002 CLK_DIV, 4, clk cycles per oversample tick; minimum 2.
REQ-003 OVERSAMPLE, 16, ticks per bit period; even, minimum 8.
REQ-004 PARITY, 0, 0 = none, 1 = even, 2 = odd.
REQ-005 STOP_BITS, 1, stop bits checked; 1 or 2.
REQ-006 clk  input  1  sole clock; one clock; all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 en_rx  input  1  receive enable; gates detection of new start bits only.
REQ-009 u_rx  input  1  asynchronous serial line, idle high.
REQ-010 data  output  DATA_BITS  last received payload, LSB first on the line.
REQ-011 u_rx_done  output  1  one-cycle pulse; frame complete.
REQ-012 parity_err  output  1  parity mismatch on last frame.
REQ-013 frame_err  output  1  a checked stop bit sampled low on last frame.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 u_rx SHALL pass a 2-flop synchronizer; all decisions use the synchronized value.
REQ-016 FSM SHALL have states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-017 IDLE->START SHALL occur on a synchronized 1->0 edge while en_rx=1; the baud counter restarts at 0 on that edge.
REQ-018 Tick SHALL assert for one clk each time the baud counter wraps from CLK_DIV-1 to 0.
REQ-019 START SHALL sample at tick OVERSAMPLE/2 after the edge; line high -> IDLE with no pulse (false start); line low -> DATA.
REQ-020 DATA, PARITY and STOP SHALL sample once per OVERSAMPLE ticks at bit centre; DATA shifts DATA_BITS bits LSB first.
REQ-021 PARITY SHALL be skipped when PARITY=0; otherwise the received bit is compared to the even or odd parity of the payload.
REQ-022 STOP SHALL sample STOP_BITS bits; any low sample sets the frame error.
REQ-023 At the final stop-bit sample: data, parity_err and frame_err SHALL update and u_rx_done SHALL pulse in the following clk.
REQ-024 The flags SHALL hold until the next u_rx_done.
REQ-025 After a good final stop bit the FSM SHALL enter IDLE in the same cycle as the u_rx_done pulse, so a start edge one clk later is accepted.
REQ-026 Final stop bit low -> BREAK; BREAK SHALL wait for the synchronized line to be high before IDLE, and no re-trigger occurs on a held-low line.
REQ-027 en_rx deasserted mid-frame SHALL NOT abort the frame.
REQ-028 Latency SHALL be a u_rx_done pulse exactly 3 clk after the sampling tick of the last stop bit (2 synchronizer + 1 register).

Reset
REQ-029 rst SHALL asynchronously set: state IDLE, counters 0, synchronizer flops 1, data 0, u_rx_done 0, parity_err 0, frame_err 0, busy 0.
REQ-030 rst mid-frame SHALL discard the partial frame with no u_rx_done.
REQ-031 After rst release, the next start edge SHALL be received normally.

Structure
REQ-032 Package uart_pkg SHALL hold the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the FSM state typedef; uart_rx_param imports it.
REQ-033 The baud/tick divider SHALL be sub-module uart_baud_gen, with ports clk, rst, restart, tick and parameter CLK_DIV.
REQ-034 Parameter legality SHALL be checked at elaboration; an illegal value is a fatal error.

Verification (CLK_DIV=4, OVERSAMPLE=16 -> 64 clk per bit)
REQ-035 Defaults, send 0xA5 with 1 stop bit -> data=0xA5, one u_rx_done pulse, both flags 0, busy 0 afterwards.
REQ-036 PARITY=1, send 0x3C with parity bit 1 -> data=0x3C, parity_err=1; resend with parity bit 0 -> parity_err=0.
REQ-037 Stop bit low, then line held low 20 bit times -> exactly one pulse with frame_err=1; line high, then send 0x55 -> data=0x55, frame_err=0.
REQ-038 Low glitch of 16 clk -> no u_rx_done; busy high for no longer than 40 clk.
REQ-039 Back-to-back 0x00 then 0xFF, no idle gap -> two pulses exactly 640 clk apart with correct data.
REQ-040 rst asserted 200 clk into a frame -> all outputs 0 immediately; next frame 0x81 is received cleanly.
